// File: rtl/mux_nin_scan.sv
// N-channel, W-bit registered multiplexer with direct-select and round-robin auto-scan modes.
// Define MUX_SCAN_MASK_EN to honour en_mask during scan; otherwise every channel is scanned.
module mux_nin_scan #(
  parameter  int N     = 4,
  parameter  int W     = 1,
  parameter  int DWELL = 4,
  localparam int SW    = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] d,
  input  logic [N-1:0]   en_mask,
  output logic [W-1:0]   q,
  output logic [SW-1:0]  cur,
  output logic           valid,
  output logic           wrap
);

  localparam int CW = (DWELL <= 2) ? 1 : $clog2(DWELL);

  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    q_q, q_d;
  logic [SW-1:0]   cur_q, cur_d;
  logic            valid_q, valid_d;
  logic            wrap_q, wrap_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [N-1:0]    en;
  logic            any_en;
  logic [SW-1:0]   low_idx;
  logic [SW-1:0]   nxt_idx;
  logic            nxt_found;
  logic [SW-1:0]   idx;
  logic            load;

`ifdef MUX_SCAN_MASK_EN
  assign en = en_mask;
`else
  // The mask is folded to all-ones so every channel takes part in the scan.
  assign en = en_mask | {N{1'b1}};
`endif

  assign any_en = |en;

  // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = mode ? ST_SCAN : ST_DIRECT;
    low_idx   = '0;
    nxt_idx   = cur_q;
    nxt_found = 1'b0;
    idx       = cur_q;
    load      = 1'b0;
    cur_d     = cur_q;
    q_d       = '0;
    valid_d   = 1'b0;
    wrap_d    = 1'b0;
    cnt_d     = '0;

    for (int i = N - 1; i >= 0; i--) begin
      if (en[i]) low_idx = SW'(i);
    end

    // Search forward from cur, wrapping modulo N; k=N lands back on cur itself.
    for (int k = 1; k <= N; k++) begin
      if (!nxt_found && en[(int'(cur_q) + k) % N]) begin
        nxt_idx   = SW'((int'(cur_q) + k) % N);
        nxt_found = 1'b1;
      end
    end

    if (!mode) begin
      if (int'(sel) < N) begin
        idx  = sel;
        load = 1'b1;
      end
    end else if (!any_en) begin
      load = 1'b0;
    end else if (state_q != ST_SCAN || !valid_q) begin
      // Scan entry, also taken when a mask bit reappears after an all-zero mask.
      idx  = low_idx;
      load = 1'b1;
    end else if (int'(cnt_q) < DWELL - 1) begin
      idx   = cur_q;
      load  = 1'b1;
      cnt_d = cnt_q + CW'(1);
    end else begin
      idx    = nxt_idx;
      load   = 1'b1;
      wrap_d = (nxt_idx <= cur_q);
    end

    if (load) begin
      cur_d   = idx;
      q_d     = d[int'(idx)*W +: W];
      valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_DIRECT;
      q_q     <= '0;
      cur_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q     = q_q;
  assign cur   = cur_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_mux_nin_scan.sv
// Directed self-checking bench for mux_nin_scan: a 4x8 instance (DWELL=4) and a 3x8 instance (DWELL=2).
module tb_mux_nin_scan;

  logic        clk = 1'b0;
  logic        rst;

  logic        mode;
  logic [1:0]  sel;
  logic [31:0] d;
  logic [3:0]  en_mask;
  logic [7:0]  q;
  logic [1:0]  cur;
  logic        valid;
  logic        wrap;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] d3;
  logic [2:0]  en3;
  logic [7:0]  q3;
  logic [1:0]  cur3;
  logic        valid3;
  logic        wrap3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_nin_scan #(.N(4), .W(8), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .d(d), .en_mask(en_mask),
    .q(q), .cur(cur), .valid(valid), .wrap(wrap)
  );

  mux_nin_scan #(.N(3), .W(8), .DWELL(2)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .d(d3), .en_mask(en3),
    .q(q3), .cur(cur3), .valid(valid3), .wrap(wrap3)
  );

  function automatic logic [7:0] chan4(input int i);
    return 8'(8'hA0 + 8'h11 * i);
  endfunction

  function automatic logic [7:0] chan3(input int i);
    return 8'(8'h11 * (i + 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [7:0] eq, input int ecur,
                        input logic ev, input logic ew);
    check($sformatf("%s.q", tag),     32'(q),     32'(eq));
    check($sformatf("%s.cur", tag),   32'(cur),   32'(ecur));
    check($sformatf("%s.valid", tag), 32'(valid), 32'(ev));
    check($sformatf("%s.wrap", tag),  32'(wrap),  32'(ew));
  endtask

  task automatic check3(input string tag, input logic [7:0] eq, input int ecur,
                        input logic ev, input logic ew);
    check($sformatf("%s.q", tag),     32'(q3),     32'(eq));
    check($sformatf("%s.cur", tag),   32'(cur3),   32'(ecur));
    check($sformatf("%s.valid", tag), 32'(valid3), 32'(ev));
    check($sformatf("%s.wrap", tag),  32'(wrap3),  32'(ew));
  endtask

  initial begin
    rst     = 1'b1;
    mode    = 1'b0;
    sel     = 2'd0;
    d       = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    en_mask = 4'b1111;
    mode3   = 1'b0;
    sel3    = 2'd0;
    d3      = {8'h33, 8'h22, 8'h11};
    en3     = 3'b111;

    tick();
    check4("reset", 8'h00, 0, 1'b0, 1'b0);
    check3("reset3", 8'h00, 0, 1'b0, 1'b0);
    rst = 1'b0;

    // Direct select steps through every channel with one-cycle latency.
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      check4($sformatf("direct%0d", s), chan4(s), s, 1'b1, 1'b0);
    end

    // Full scan: each channel for 4 cycles, wrap only when cur returns to 0.
    mode = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      check4($sformatf("scan_t%0d", t), chan4((t / 4) % 4), (t / 4) % 4, 1'b1,
             (t > 0 && t % 16 == 0));
    end

    // Reset mid-scan overrides mode.
    rst = 1'b1;
    tick();
    check4("rst_midscan", 8'h00, 0, 1'b0, 1'b0);
    rst = 1'b0;

    tick();
    check4("reentry_t0", chan4(0), 0, 1'b1, 1'b0);
    tick();
    check4("reentry_t1", chan4(0), 0, 1'b1, 1'b0);

    // Drop to direct mid-dwell, then re-enter scan from the lowest channel with a full dwell.
    mode = 1'b0;
    sel  = 2'd2;
    tick();
    check4("to_direct", chan4(2), 2, 1'b1, 1'b0);
    mode = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      check4($sformatf("restart_t%0d", t), chan4(t / 4), t / 4, 1'b1, 1'b0);
    end

    mode = 1'b0;
    sel  = 2'd0;
    tick();
    check4("leave_scan", chan4(0), 0, 1'b1, 1'b0);

`ifdef MUX_SCAN_MASK_EN
    // Mask 1010: alternate 1,3 with wrap on each 3->1.
    en_mask = 4'b1010;
    mode    = 1'b1;
    for (int t = 0; t < 16; t++) begin
      tick();
      check4($sformatf("mask1010_t%0d", t), chan4(((t / 4) % 2 == 1) ? 3 : 1),
             ((t / 4) % 2 == 1) ? 3 : 1, 1'b1, (t > 0 && t % 8 == 0));
    end

    // Single enabled channel re-selects itself and wraps every dwell.
    mode = 1'b0;
    tick();
    en_mask = 4'b0100;
    mode    = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick();
      check4($sformatf("mask0100_t%0d", t), chan4(2), 2, 1'b1, (t > 0 && t % 4 == 0));
    end

    // Empty mask: output invalid, cur holds; a new bit is treated as scan entry.
    en_mask = 4'b0000;
    tick();
    check4("mask0_a", 8'h00, 2, 1'b0, 1'b0);
    tick();
    check4("mask0_b", 8'h00, 2, 1'b0, 1'b0);
    en_mask = 4'b0001;
    tick();
    check4("mask0001", chan4(0), 0, 1'b1, 1'b0);
`else
    // Without the mask feature a sparse mask still scans all four channels.
    en_mask = 4'b1010;
    mode    = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      check4($sformatf("nomask_t%0d", t), chan4(t / 4), t / 4, 1'b1, 1'b0);
    end
    mode = 1'b0;
    tick();
    en_mask = 4'b0000;
    mode    = 1'b1;
    tick();
    check4("nomask_zero", chan4(0), 0, 1'b1, 1'b0);
`endif

    // N=3: out-of-range select clears q and valid while cur holds.
    sel3 = 2'd1;
    tick();
    check3("n3_sel1", chan3(1), 1, 1'b1, 1'b0);
    sel3 = 2'd3;
    tick();
    check3("n3_sel3", 8'h00, 1, 1'b0, 1'b0);

    // N=3 scan with DWELL=2: 0,0,1,1,2,2,0 and wrap on 2->0.
    mode3 = 1'b1;
    for (int t = 0; t < 7; t++) begin
      tick();
      check3($sformatf("n3_scan_t%0d", t), chan3((t / 2) % 3), (t / 2) % 3, 1'b1, (t == 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
